// File: rtl/branch_predictor_table.sv
// branch_predictor_table
// PC-indexed table of saturating counters used by the ID stage to predict
// conditional branches. Index is either the PC word address (bimodal) or the
// PC word address XOR a global taken/not-taken history (gshare). The branch
// predicted in ID is carried one stage into EX, where it is resolved against
// the ALU outcome; a wrong guess raises a single-cycle flush and a redirect.
// Two performance counters report resolved branches and mispredicts.

module branch_predictor_table #(
  parameter int IDX_W  = 4,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 4,
  parameter int MODE   = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lookup_valid_i,
  input  logic [31:0]      lookup_pc_i,
  input  logic             stall_i,
  input  logic             resolve_taken_i,
  output logic             predict_o,
  output logic             mispredict_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             redirect_taken_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int ENTRIES = 1 << IDX_W;

  // Counters come out of reset weakly taken: MSB set, all other bits clear.
  localparam logic [CTR_W-1:0] CTR_WEAK_T = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_MAX    = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ZERO   = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_ONE    = {{(CTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Prediction table
  logic [CTR_W-1:0]  table_q [ENTRIES];
  logic [CTR_W-1:0]  table_d [ENTRIES];

  // Global history, shifted only when a branch actually resolves
  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_d;

  // EX slot: the branch that was looked up in ID on the previous cycle
  logic              ex_valid_q;
  logic              ex_valid_d;
  logic              ex_pred_q;
  logic              ex_pred_d;
  logic [IDX_W-1:0]  ex_idx_q;
  logic [IDX_W-1:0]  ex_idx_d;
  logic [HIST_W-1:0] ex_ghr_q;
  logic [HIST_W-1:0] ex_ghr_d;

  // Performance counters
  logic [CNT_W-1:0]  branch_cnt_q;
  logic [CNT_W-1:0]  branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q;
  logic [CNT_W-1:0]  mispred_cnt_d;

  // Lookup path
  logic [IDX_W-1:0]  pc_idx;
  logic [IDX_W-1:0]  hist_idx;
  logic [IDX_W-1:0]  lookup_idx;
  logic [CTR_W-1:0]  lookup_ctr;
  logic [CTR_W-1:0]  upd_ctr;

  // PC byte offset and high bits never reach the index, and the history
  // snapshot in the EX slot is kept only for debug visibility.
  logic              unused_bits;
  assign unused_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0], ex_ghr_q};

  // Index generation: word address, optionally hashed with the history
  always_comb begin
    pc_idx     = lookup_pc_i[IDX_W+1:2];
    hist_idx   = (MODE == 1) ? IDX_W'(ghr_q) : {IDX_W{1'b0}};
    lookup_idx = pc_idx ^ hist_idx;
    lookup_ctr = table_q[lookup_idx];
  end

  // Prediction and resolution outputs; prediction is forced low in reset
  // because the table already holds weakly-taken values while rst_i is low.
  always_comb begin
    predict_o        = rst_i & lookup_valid_i & lookup_ctr[CTR_W-1];
    mispredict_o     = ex_valid_q & (resolve_taken_i != ex_pred_q);
    flush_ifid_o     = mispredict_o;
    flush_idex_o     = mispredict_o;
    redirect_taken_o = ex_valid_q & resolve_taken_i & mispredict_o;
    branch_cnt_o     = branch_cnt_q;
    mispred_cnt_o    = mispred_cnt_q;
  end

  // EX slot capture: stalls become bubbles, a mispredict squashes the ID branch
  always_comb begin
    ex_valid_d = lookup_valid_i & ~stall_i & ~mispredict_o;
    ex_pred_d  = predict_o;
    ex_idx_d   = lookup_idx;
    ex_ghr_d   = ghr_q;
  end

  // Counter training on the captured index, saturating at both ends
  always_comb begin
    table_d = table_q;
    upd_ctr = table_q[ex_idx_q];
    if (ex_valid_q) begin
      if (resolve_taken_i) begin
        if (upd_ctr != CTR_MAX) begin
          table_d[ex_idx_q] = upd_ctr + CTR_ONE;
        end
      end else begin
        if (upd_ctr != CTR_ZERO) begin
          table_d[ex_idx_q] = upd_ctr - CTR_ONE;
        end
      end
    end
  end

  // History shift at resolution only (gshare); bimodal keeps it at zero
  always_comb begin
    ghr_d = ghr_q;
    if ((MODE == 1) && ex_valid_q) begin
      ghr_d = (ghr_q << 1) | HIST_W'(resolve_taken_i);
    end
  end

  // Performance counters advance per resolved branch and wrap naturally
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ex_valid_q) begin
      branch_cnt_d = branch_cnt_q + CNT_ONE;
      if (mispredict_o) begin
        mispred_cnt_d = mispred_cnt_q + CNT_ONE;
      end
    end
  end

  // Table storage
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CTR_WEAK_T;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

  // History, EX slot and performance counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ghr_q         <= {HIST_W{1'b0}};
      ex_valid_q    <= 1'b0;
      ex_pred_q     <= 1'b0;
      ex_idx_q      <= {IDX_W{1'b0}};
      ex_ghr_q      <= {HIST_W{1'b0}};
      branch_cnt_q  <= {CNT_W{1'b0}};
      mispred_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ghr_q         <= ghr_d;
      ex_valid_q    <= ex_valid_d;
      ex_pred_q     <= ex_pred_d;
      ex_idx_q      <= ex_idx_d;
      ex_ghr_q      <= ex_ghr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- Parametrised successor to the single-counter branch predictor in the 5-stage pipelined CPU.
- Keeps a table of saturating counters indexed by PC, either bimodal or gshare with a global history register.
- Predicts in ID, tracks the in-flight branch into EX, resolves it against the ALU zero flag, and drives the flush and PC-redirect controls.
- Also keeps branch and mispredict performance counters.

Parameters:
- IDX_W, 4: table index width; table has 2^IDX_W entries.
- CTR_W, 2: saturating counter width, minimum 2.
- HIST_W, 4: global history width, at most IDX_W; ignored when MODE=0.
- MODE, 0: 0 = bimodal (index = pc[IDX_W+1:2]); 1 = gshare (index = pc[IDX_W+1:2] XOR zero-extended ghr).
- CNT_W, 16: performance counter width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- lookup_valid_i  input  1  ID-stage instruction is a branch (Control Branch).
- lookup_pc_i  input  32  PC of the ID-stage instruction.
- stall_i  input  1  load-use stall from hazard detection; the ID instruction does not advance.
- resolve_taken_i  input  1  EX-stage actual outcome (ALU zero for beq).
- predict_o  output  1  prediction for the ID branch: lookup_valid_i AND counter MSB.
- mispredict_o  output  1  EX branch outcome differs from its prediction.
- flush_ifid_o  output  1  equals mispredict_o.
- flush_idex_o  output  1  equals mispredict_o.
- redirect_taken_o  output  1  valid only with mispredict_o.
  - 1: redirect to the branch target (EX pc + imm).
  - 0: redirect to EX pc + 4.
- branch_cnt_o  output  CNT_W  branches resolved since reset.
- mispred_cnt_o  output  CNT_W  mispredicts since reset.

Behaviour:
- Reset (rst_i low, asynchronous):
  - All counters set to 2^(CTR_W-1) (weakly taken).
  - ghr = 0.
  - EX slot: ex_valid = 0, ex_pred = 0, ex_idx = 0, ex_ghr = 0.
  - Performance counters = 0.
  - All outputs 0 while in reset.
  - Reset mid-operation discards any in-flight branch; no flush is generated.
- Lookup (combinational):
  - idx computed from lookup_pc_i and the current ghr.
  - predict_o = lookup_valid_i & table[idx][CTR_W-1].
  - Read returns the pre-update value even if the same entry is written that cycle; no bypass.
- EX slot capture, every edge:
  - ex_valid <= lookup_valid_i & ~stall_i & ~mispredict_o.
  - ex_pred <= predict_o.
  - ex_idx <= idx.
  - ex_ghr <= ghr.
  - A stall turns the EX slot into a bubble, matching the ID/EX NoOp. The branch re-looks-up next cycle.
  - A mispredict squashes the ID instruction, so the slot is not captured.
- Resolution (combinational outputs):
  - mispredict_o = ex_valid & (resolve_taken_i != ex_pred).
  - redirect_taken_o = ex_valid & resolve_taken_i & mispredict_o.
- Update, on the edge when ex_valid = 1:
  - table[ex_idx] increments if taken (saturating at 2^CTR_W-1), else decrements (saturating at 0).
  - MODE=1: ghr <= {ghr[HIST_W-2:0], resolve_taken_i}, updated non-speculatively and only at resolution.
  - The update always uses the captured ex_idx, never a recomputed index.
- Performance counters, on the edge when ex_valid = 1:
  - branch_cnt_o increments.
  - mispred_cnt_o increments when mispredict_o = 1.
  - Both wrap modulo 2^CNT_W.
- Latency:
  - Prediction: 0 cycles.
  - Resolution: exactly 1 cycle after a non-stalled lookup.
  - Flush: single-cycle pulse per mispredict.
- Back-to-back branches in ID and EX:
  - If the EX branch mispredicts, the ID branch's lookup is squashed and its counter is untouched.
  - Otherwise both proceed normally.

Test Plan:
1. Reset, then release; lookup pc 0x10 with valid=1 -> predict_o=1 (counter 2); before release all outputs 0 and both counts 0.
2. Branch at pc 0x10 resolved not-taken twice, MODE=0:
   - 1st resolution: mispredict_o, flush_ifid_o and flush_idex_o pulse 1 for one cycle; redirect_taken_o=0; counter 2->1.
   - 2nd resolution: predict_o=0 at lookup, no mispredict, counter 1->0.
   - End state: branch_cnt_o=2, mispred_cnt_o=1.
3. Saturation, CTR_W=3: seven taken resolutions at pc 0x20 -> counter 4->7 and held at 7; one not-taken -> 6; next predict_o=1.
4. Aliasing, IDX_W=4:
   - Train pc 0x14 (idx 5) to 0 with two not-taken.
   - pc 0x54 (also idx 5) then predicts 0.
   - pc 0x10 (idx 4) still predicts 1.
5. Stall and squash:
   - lookup_valid_i=1 with stall_i=1 -> next cycle mispredict_o=0 for either resolve_taken_i, and counts unchanged.
   - Mispredicting EX branch with a branch in ID -> the ID branch is not counted the following cycle.
6. Gshare and async reset, MODE=1, HIST_W=4:
   - Resolve T,T,N,T -> ghr=4'b1101.
   - Lookup pc 0x10 reads and updates idx 4^13=9 (verify via the trained entry).
   - Asserting rst_i low mid-cycle with ex_valid=1 clears ghr, outputs and counts immediately.
